// File: rtl/bubble_thermal_pkg.sv
// Shared definitions for the BubbleDrive8 thermal controller: FSM encoding,
// TC77 word layout and the fixed-point slope multiply.
package bubble_thermal_pkg;

    localparam int TC_W        = 14;
    localparam int TC_TEMP_MSB = 13;
    localparam int TC_TEMP_LSB = 1;
    localparam int TC_DONE_BIT = 0;
    localparam int TEMP_W      = TC_TEMP_MSB - TC_TEMP_LSB + 1;

    localparam int DEG_LSB    = 16;
    localparam int PROD_W     = 30;
    // 1/16 degC temperature times Q8.8 slope leaves 4 + 8 fraction bits
    localparam int SECS_SHIFT = 12;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL,
        ST_RT_TICK,
        ST_RT_LOAD,
        ST_RT_WAIT,
        ST_RT_CHK,
        ST_RT_MUL,
        ST_RT_SUM,
        ST_FAILSAFE,
        ST_DLY,
        ST_REL,
        ST_FAN_IDLE,
        ST_FAN_LOAD,
        ST_FAN_WAIT,
        ST_FAN_UPD
    } state_e;

    function automatic logic signed [PROD_W-1:0] q88_mul(
        input logic signed [TEMP_W-1:0] temp,
        input logic        [15:0]       slope
    );
        logic signed [PROD_W-1:0] t_ext;
        logic signed [PROD_W-1:0] s_ext;
        t_ext = PROD_W'(temp);
        s_ext = PROD_W'($signed({1'b0, slope}));
        return t_ext * s_ext;
    endfunction

endpackage

// File: rtl/bubble_thermal_if.sv
// TC77 loader handshake: the controller pulses nLOAD, the loader answers
// with nCOMPLETE low while TEMPDATA holds the sensor word.
interface bubble_thermal_if;
    import bubble_thermal_pkg::*;

    logic            nLOAD;
    logic            nCOMPLETE;
    logic [TC_W-1:0] TEMPDATA;

    modport master (output nLOAD, input nCOMPLETE, input TEMPDATA);
    modport slave  (input nLOAD, output nCOMPLETE, output TEMPDATA);

endinterface

// File: rtl/thermal_sec_tick.sv
// One-second prescaler: emits a single-cycle tick every CLK_HZ cycles and
// restarts its count whenever clr is high.
module thermal_sec_tick #(
    parameter int CLK_HZ = 48_000_000
) (
    input  logic MCLK,
    input  logic nRESET,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [CW-1:0] cnt;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge MCLK) begin
        if (!nRESET || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(CLK_HZ - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/bubble_thermal_ctrl.sv
// BubbleDrive8 startup-delay and staged fan controller.
// Define BUBBLE_THERMAL_HYST_EN to add turn-off hysteresis to the fan stages.
module bubble_thermal_ctrl
    import bubble_thermal_pkg::*;
#(
    parameter int          CLK_HZ      = 48_000_000,
    parameter int          NUM_FANS    = 2,
    parameter int          DELAY_S0    = 2,
    parameter int          DELAY_S1    = 80,
    parameter int          DELAY_S2    = 260,
    parameter int          INTERCEPT_S = 488,
    parameter logic [15:0] SLOPE_Q88   = 16'h10CD,
    parameter int          SKIP_C      = 29,
    parameter int          MAX_DELAY_S = 600,
    parameter int          CHECK_S     = 20,
    parameter int          FAN_ON_C    = 38,
    parameter int          FAN_STEP_C  = 4,
    parameter int          FAN_HYST_C  = 2,
    parameter int          SENSOR_TO   = 1_000_000,
    parameter int          MAX_RETRY   = 8
) (
    input  logic                MCLK,
    input  logic                nRESET,
    input  logic                nEN,
    input  logic [1:0]          MODE,
    input  logic                FAN_EN,
    input  logic                FORCESTART,
    bubble_thermal_if.master    sensor,
    output logic                nDELAYING,
    output logic                nTEMPLO,
    output logic [NUM_FANS-1:0] nFANEN,
    output logic                nSENSERR,
    output logic [15:0]         DELAY_LEFT
);

    localparam int WAIT_W   = $clog2(SENSOR_TO + 1);
    localparam int CHECK_W  = $clog2(CHECK_S + 1);
    localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
    localparam int SKIP_RAW = SKIP_C * DEG_LSB;
`ifdef BUBBLE_THERMAL_HYST_EN
    // A stage drops out only once T is below threshold minus the band
    localparam int OFF_DROP = FAN_HYST_C * DEG_LSB + 1;
`else
    localparam int OFF_DROP = 0;
`endif

    state_e                    state, next_state;
    logic                      tick, tick_clr;
    logic [1:0]                mode_q;
    logic [TC_W-1:0]           temp_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic [RETRY_W-1:0]        retry_q;
    logic [WAIT_W-1:0]         wait_q;
    logic [CHECK_W-1:0]        check_q;
    logic [15:0]               delay_q;
    logic [NUM_FANS-1:0]       fan_q;
    logic                      serr_q;
    logic                      n_load_q;
    logic                      rel_q;

    logic signed [TEMP_W-1:0]  temp_s;
    logic                      temp_done;
    logic                      wait_expired;
    logic                      retry_last;
    logic                      check_last;
    logic signed [PROD_W-1:0]  secs_full;
    int                        dly_int;
    logic [15:0]               delay_calc;
    logic [NUM_FANS-1:0]       fan_next;

    assign temp_s       = $signed(temp_q[TC_TEMP_MSB:TC_TEMP_LSB]);
    assign temp_done    = temp_q[TC_DONE_BIT];
    assign wait_expired = (wait_q == WAIT_W'(SENSOR_TO - 1));
    assign retry_last   = (retry_q == RETRY_W'(MAX_RETRY - 1));
    assign check_last   = (check_q == CHECK_W'(CHECK_S - 1));

    thermal_sec_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .MCLK   (MCLK),
        .nRESET (nRESET),
        .clr    (tick_clr),
        .tick   (tick)
    );

    always_ff @(posedge MCLK) begin
        if (!nRESET) state <= ST_IDLE;
        else         state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        tick_clr   = 1'b0;
        unique case (state)
            ST_IDLE:     next_state = ST_SEL;
            ST_SEL:      next_state = (mode_q == 2'd3) ? ST_RT_TICK : ST_DLY;
            ST_RT_TICK:  if (tick) next_state = ST_RT_LOAD;
            ST_RT_LOAD:  next_state = ST_RT_WAIT;
            ST_RT_WAIT:  if (!sensor.nCOMPLETE) next_state = ST_RT_CHK;
                         else if (wait_expired) next_state = ST_FAILSAFE;
            ST_RT_CHK:   if (!temp_done)
                             next_state = retry_last ? ST_DLY : ST_RT_TICK;
                         else if (int'(temp_s) > SKIP_RAW)
                             next_state = ST_REL;
                         else
                             next_state = ST_RT_MUL;
            ST_RT_MUL:   next_state = ST_RT_SUM;
            ST_RT_SUM:   next_state = ST_DLY;
            ST_FAILSAFE: next_state = ST_DLY;
            ST_DLY:      if (FORCESTART || delay_q == '0) next_state = ST_REL;
            ST_REL:      next_state = ST_FAN_IDLE;
            ST_FAN_IDLE: if (FAN_EN && tick && check_last) next_state = ST_FAN_LOAD;
            ST_FAN_LOAD: next_state = ST_FAN_WAIT;
            ST_FAN_WAIT: if (!sensor.nCOMPLETE || wait_expired) next_state =
                             sensor.nCOMPLETE ? ST_FAN_IDLE : ST_FAN_UPD;
            ST_FAN_UPD:  next_state = ST_FAN_IDLE;
            default:     next_state = ST_IDLE;
        endcase
        if (nEN) next_state = ST_IDLE;
        // Prescaler restarts on every state entry and while fan checks are paused
        tick_clr = (next_state != state) || (state == ST_FAN_IDLE && !FAN_EN);
    end

    always_comb begin
        secs_full = prod_q >>> SECS_SHIFT;
        dly_int   = INTERCEPT_S - int'(secs_full);
        if (dly_int < 0)                dly_int = 0;
        else if (dly_int > MAX_DELAY_S) dly_int = MAX_DELAY_S;
        delay_calc = 16'(dly_int);

        fan_next = fan_q;
        for (int k = 0; k < NUM_FANS; k++) begin
            int thr;
            thr = (FAN_ON_C + k * FAN_STEP_C) * DEG_LSB;
            if (int'(temp_s) > thr)                  fan_next[k] = 1'b0;
            else if (int'(temp_s) <= thr - OFF_DROP) fan_next[k] = 1'b1;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!nRESET || nEN) begin
            mode_q   <= '0;
            temp_q   <= '0;
            prod_q   <= '0;
            retry_q  <= '0;
            wait_q   <= '0;
            check_q  <= '0;
            delay_q  <= '0;
            fan_q    <= '1;
            serr_q   <= 1'b1;
            n_load_q <= 1'b1;
            rel_q    <= 1'b0;
        end else begin
            n_load_q <= !(next_state == ST_RT_LOAD || next_state == ST_FAN_LOAD);
            rel_q    <= (next_state inside {ST_REL, ST_FAN_IDLE, ST_FAN_LOAD,
                                            ST_FAN_WAIT, ST_FAN_UPD});

            if (state == ST_RT_WAIT || state == ST_FAN_WAIT) wait_q <= wait_q + WAIT_W'(1);
            else                                             wait_q <= '0;

            if (state != ST_FAN_IDLE || !FAN_EN) check_q <= '0;
            else if (tick)                       check_q <= check_q + CHECK_W'(1);

            if ((state == ST_RT_WAIT || state == ST_FAN_WAIT) && !sensor.nCOMPLETE)
                temp_q <= sensor.TEMPDATA;

            unique case (state)
                ST_IDLE: begin
                    mode_q  <= MODE;
                    retry_q <= '0;
                end
                ST_SEL: begin
                    case (mode_q)
                        2'd0:    delay_q <= 16'(DELAY_S0);
                        2'd1:    delay_q <= 16'(DELAY_S1);
                        2'd2:    delay_q <= 16'(DELAY_S2);
                        default: delay_q <= '0;
                    endcase
                end
                ST_RT_CHK: begin
                    if (!temp_done) begin
                        retry_q <= retry_q + RETRY_W'(1);
                        if (retry_last) delay_q <= 16'(DELAY_S2);
                    end
                end
                ST_RT_MUL: prod_q  <= q88_mul(temp_s, SLOPE_Q88);
                ST_RT_SUM: delay_q <= delay_calc;
                ST_FAILSAFE: begin
                    serr_q  <= 1'b0;
                    delay_q <= 16'(DELAY_S2);
                end
                ST_DLY: begin
                    if (FORCESTART)                 delay_q <= '0;
                    else if (tick && delay_q != '0) delay_q <= delay_q - 16'd1;
                end
                ST_FAN_WAIT: begin
                    if (sensor.nCOMPLETE && wait_expired) begin
                        serr_q <= 1'b0;
                        fan_q  <= '0;
                    end
                end
                ST_FAN_UPD: if (temp_done) fan_q <= fan_next;
                default: ;
            endcase
        end
    end

    assign sensor.nLOAD = n_load_q;
    assign nDELAYING    = rel_q;
    assign nTEMPLO      = rel_q;
    assign nFANEN       = fan_q;
    assign nSENSERR     = serr_q;
    assign DELAY_LEFT   = delay_q;

endmodule

// File: tb/tb_bubble_thermal_ctrl.sv
// Directed bench for bubble_thermal_ctrl with a 16-cycle second and a
// 64-cycle sensor timeout; a behavioural TC77 loader answers nLOAD pulses.
module tb_bubble_thermal_ctrl;
    import bubble_thermal_pkg::*;

    localparam int NF = 2;

    logic          MCLK = 1'b0;
    logic          nRESET, nEN, FAN_EN, FORCESTART;
    logic [1:0]    MODE;
    logic          nDELAYING, nTEMPLO, nSENSERR;
    logic [NF-1:0] nFANEN;
    logic [15:0]   DELAY_LEFT;

    bubble_thermal_if sif();

    bubble_thermal_ctrl #(.CLK_HZ(16), .NUM_FANS(NF), .SENSOR_TO(64)) dut (
        .MCLK       (MCLK),
        .nRESET     (nRESET),
        .nEN        (nEN),
        .MODE       (MODE),
        .FAN_EN     (FAN_EN),
        .FORCESTART (FORCESTART),
        .sensor     (sif),
        .nDELAYING  (nDELAYING),
        .nTEMPLO    (nTEMPLO),
        .nFANEN     (nFANEN),
        .nSENSERR   (nSENSERR),
        .DELAY_LEFT (DELAY_LEFT)
    );

    always #5 MCLK = ~MCLK;

    int          total = 0;
    int          bad   = 0;
    int          load_cnt = 0;
    bit          sens_en = 1'b1;
    logic [13:0] sens_word = '0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    function automatic logic [13:0] tw(input int raw, input bit done);
        logic [12:0] t;
        t = 13'(raw);
        return {t, done};
    endfunction

    // TC77 loader: answers each nLOAD pulse one cycle later with a 1-cycle nCOMPLETE
    initial begin
        sif.nCOMPLETE = 1'b1;
        sif.TEMPDATA  = '0;
        forever begin
            @(negedge MCLK);
            if (sif.nLOAD === 1'b0) begin
                load_cnt++;
                if (sens_en) begin
                    @(negedge MCLK);
                    sif.nCOMPLETE = 1'b0;
                    sif.TEMPDATA  = sens_word;
                    @(negedge MCLK);
                    sif.nCOMPLETE = 1'b1;
                end
            end
        end
    end

    typedef struct packed {
        logic [1:0]  mode;
        logic        sens;
        logic [13:0] word;
        int          dl;
        int          rel;
        int          serr;
        int          loads;
    } vec_t;

    vec_t vecs [10];

    task automatic fan_sample(input string name, input logic [13:0] word, input int exp);
        int snap, n;
        sens_word = word;
        snap = load_cnt;
        n = 0;
        while (load_cnt == snap && n < 500) begin cycles(1); n++; end
        check({name, "_load"}, int'(n < 500), 1);
        cycles(4);
        check(name, int'(nFANEN), exp);
    endtask

    initial begin
        int n, snap, prev, decs, steps_bad;
        int exp_hyst;

        vecs[0] = '{mode: 2'd0, sens: 1'b1, word: tw(0, 1'b1),    dl: 2,   rel: 0, serr: 1, loads: 0};
        vecs[1] = '{mode: 2'd2, sens: 1'b1, word: tw(0, 1'b1),    dl: 260, rel: 0, serr: 1, loads: 0};
        vecs[2] = '{mode: 2'd3, sens: 1'b1, word: tw(320, 1'b1),  dl: 152, rel: 0, serr: 1, loads: 1};
        vecs[3] = '{mode: 2'd3, sens: 1'b1, word: tw(-160, 1'b1), dl: 600, rel: 0, serr: 1, loads: 1};
        vecs[4] = '{mode: 2'd3, sens: 1'b1, word: tw(0, 1'b1),    dl: 488, rel: 0, serr: 1, loads: 1};
        vecs[5] = '{mode: 2'd3, sens: 1'b1, word: tw(464, 1'b1),  dl: 1,   rel: 0, serr: 1, loads: 1};
        vecs[6] = '{mode: 2'd3, sens: 1'b1, word: tw(465, 1'b1),  dl: 0,   rel: 1, serr: 1, loads: 1};
        vecs[7] = '{mode: 2'd3, sens: 1'b1, word: tw(480, 1'b1),  dl: 0,   rel: 1, serr: 1, loads: 1};
        vecs[8] = '{mode: 2'd3, sens: 1'b1, word: tw(320, 1'b0),  dl: 260, rel: 0, serr: 1, loads: 8};
        vecs[9] = '{mode: 2'd3, sens: 1'b0, word: tw(320, 1'b1),  dl: 260, rel: 0, serr: 0, loads: 1};

        nRESET = 1'b0; nEN = 1'b1; MODE = 2'd0; FAN_EN = 1'b0; FORCESTART = 1'b0;
        cycles(3);
        check("rst_nload",     int'(sif.nLOAD), 1);
        check("rst_ndelaying", int'(nDELAYING), 0);
        check("rst_ntemplo",   int'(nTEMPLO),   0);
        check("rst_nfanen",    int'(nFANEN),    3);
        check("rst_nsenserr",  int'(nSENSERR),  1);
        check("rst_delayleft", int'(DELAY_LEFT), 0);
        nRESET = 1'b1;
        cycles(2);

        for (int i = 0; i < 10; i++) begin
            nEN = 1'b1;
            cycles(2);
            MODE      = vecs[i].mode;
            sens_en   = vecs[i].sens;
            sens_word = vecs[i].word;
            snap      = load_cnt;
            nEN       = 1'b0;
            n = 0;
            while (DELAY_LEFT == 0 && nDELAYING == 1'b0 && n < 3000) begin cycles(1); n++; end
            check($sformatf("vec%0d_reached", i), int'(n < 3000), 1);
            check($sformatf("vec%0d_delayleft", i), int'(DELAY_LEFT), vecs[i].dl);
            check($sformatf("vec%0d_ndelaying", i), int'(nDELAYING), vecs[i].rel);
            check($sformatf("vec%0d_nsenserr", i), int'(nSENSERR), vecs[i].serr);
            check($sformatf("vec%0d_loads", i), load_cnt - snap, vecs[i].loads);
            nEN = 1'b1;
            cycles(1);
            check($sformatf("vec%0d_idle_dl", i), int'(DELAY_LEFT), 0);
            check($sformatf("vec%0d_idle_ndly", i), int'(nDELAYING), 0);
            check($sformatf("vec%0d_idle_serr", i), int'(nSENSERR), 1);
        end
        sens_en = 1'b1;

        // MODE 1 full countdown: 80 ticks of 16 cycles, release 2 cycles after the last tick
        cycles(2);
        MODE = 2'd1;
        nEN  = 1'b0;
        n = 0;
        while (DELAY_LEFT == 0 && n < 10) begin cycles(1); n++; end
        check("cnt_start", int'(DELAY_LEFT), 80);
        prev = 80; decs = 0; steps_bad = 0; n = 0;
        while (nDELAYING == 1'b0 && n < 2000) begin
            cycles(1);
            n++;
            if (int'(DELAY_LEFT) != prev) begin
                if (int'(DELAY_LEFT) != prev - 1) steps_bad++;
                decs++;
                prev = int'(DELAY_LEFT);
            end
        end
        check("cnt_release_cycle", n, 1282);
        check("cnt_decrements", decs, 80);
        check("cnt_bad_steps", steps_bad, 0);
        check("cnt_ntemplo", int'(nTEMPLO), 1);
        check("cnt_final_dl", int'(DELAY_LEFT), 0);

        // FORCESTART at DELAY_LEFT=50 releases on the next cycle
        nEN = 1'b1;
        cycles(2);
        nEN = 1'b0;
        n = 0;
        while (DELAY_LEFT != 16'd50 && n < 1500) begin cycles(1); n++; end
        check("force_reached50", int'(n < 1500), 1);
        FORCESTART = 1'b1;
        cycles(1);
        check("force_ndelaying", int'(nDELAYING), 1);
        check("force_dl", int'(DELAY_LEFT), 0);
        FORCESTART = 1'b0;

        // Fan stages: thresholds 38 and 42 degC
        cycles(5);
        check("fan_hold_off", int'(nFANEN), 3);
        sens_word = tw(640, 1'b1);
        FAN_EN = 1'b1;
        fan_sample("fan_40c", tw(640, 1'b1), 2);
        fan_sample("fan_43c", tw(688, 1'b1), 0);
`ifdef BUBBLE_THERMAL_HYST_EN
        exp_hyst = 2;
`else
        exp_hyst = 3;
`endif
        fan_sample("fan_37c", tw(592, 1'b1), exp_hyst);
        fan_sample("fan_35c", tw(560, 1'b1), 3);
        fan_sample("fan_notdone", tw(688, 1'b0), 3);

        // FAN_WAIT timeout forces every stage on and flags the sensor
        sens_en = 1'b0;
        snap = load_cnt;
        n = 0;
        while (load_cnt == snap && n < 500) begin cycles(1); n++; end
        check("fan_to_load", int'(n < 500), 1);
        cycles(70);
        check("fan_to_senserr", int'(nSENSERR), 0);
        check("fan_to_nfanen", int'(nFANEN), 0);
        check("fan_to_ndly", int'(nDELAYING), 1);
        sens_en = 1'b1;

        nRESET = 1'b0;
        cycles(1);
        check("rstfan_nfanen", int'(nFANEN), 3);
        check("rstfan_senserr", int'(nSENSERR), 1);
        check("rstfan_ndly", int'(nDELAYING), 0);
        FAN_EN = 1'b0;
        MODE   = 2'd2;
        nRESET = 1'b1;

        // Reset in the middle of a running delay
        n = 0;
        while (DELAY_LEFT == 0 && n < 10) begin cycles(1); n++; end
        check("rstdly_start", int'(DELAY_LEFT), 260);
        cycles(40);
        check("rstdly_running", int'(DELAY_LEFT), 258);
        nRESET = 1'b0;
        cycles(1);
        check("rstdly_dl", int'(DELAY_LEFT), 0);
        check("rstdly_ndly", int'(nDELAYING), 0);
        check("rstdly_nload", int'(sif.nLOAD), 1);
        nRESET = 1'b1;
        nEN    = 1'b1;
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
